// File: rtl/pid_controller.sv
// Pipelined PID loop: input capture, S1 error, S2 products, S3 integrate/sum, S4 saturate/register.
// Define PID_DERIVATIVE_EN to build the derivative path; otherwise d is zero and kd is ignored.
module pid_controller #(
   parameter int SHIFT_P   = 8,
   parameter int SHIFT_I   = 12,
   parameter int SHIFT_D   = 8,
   parameter int INT_WIDTH = 40
) (
   input  logic               master_clk,
   input  logic               reset,
   input  logic signed [13:0] err_in,
   input  logic               err_strobe,
   input  logic signed [13:0] setpoint,
   input  logic signed [15:0] kp,
   input  logic signed [15:0] ki,
   input  logic signed [15:0] kd,
   input  logic               enable,
   input  logic               hold_int,
   output logic signed [13:0] pid_out,
   output logic               out_valid,
   output logic               sat
);

   localparam int SUM_W = ((INT_WIDTH > 32) ? INT_WIDTH : 32) + 2;
   localparam logic signed [INT_WIDTH-1:0] INT_MAX = {1'b0, {(INT_WIDTH-1){1'b1}}};
   localparam logic signed [INT_WIDTH-1:0] INT_MIN = {1'b1, {(INT_WIDTH-1){1'b0}}};
   localparam logic signed [SUM_W-1:0]     OUT_MAX = SUM_W'(8191);
   localparam logic signed [SUM_W-1:0]     OUT_MIN = SUM_W'(-8192);

   logic               v0, v1, v2, v3;
   logic signed [13:0] err0, sp0;
   logic signed [14:0] e_c, e1;
   logic signed [30:0] kp_e, ki_e, p2;
   logic signed [INT_WIDTH-1:0] iinc2, integ, integ_new, integ_next;
   logic signed [INT_WIDTH:0]   integ_wide;
   logic signed [SUM_W-1:0]     sum_c, sum3;
   logic               freeze;

   always_ff @(posedge master_clk) begin
      if (reset) begin
         v0   <= 1'b0;
         err0 <= '0;
         sp0  <= '0;
      end else begin
         v0 <= err_strobe;
         if (err_strobe) begin
            err0 <= err_in;
            sp0  <= setpoint;
         end
      end
   end

   assign e_c = 15'(sp0) - 15'(err0);

`ifdef PID_DERIVATIVE_EN
   logic signed [14:0] e_prev;
   logic signed [15:0] de_c, de1;
   logic signed [31:0] kd_de, d2;
   assign de_c  = 16'(e_c) - 16'(e_prev);
   assign kd_de = 32'(kd) * 32'(de1);
`else
   logic unused_kd;
   assign unused_kd = ^kd;
`endif

   always_ff @(posedge master_clk) begin
      if (reset) begin
         v1 <= 1'b0;
         e1 <= '0;
`ifdef PID_DERIVATIVE_EN
         de1    <= '0;
         e_prev <= '0;
`endif
      end else begin
         v1 <= v0;
         if (v0) e1 <= e_c;
`ifdef PID_DERIVATIVE_EN
         if (v0) de1 <= de_c;
         if (!enable)  e_prev <= '0;
         else if (v0)  e_prev <= e_c;
`endif
      end
   end

   assign kp_e = 31'(kp) * 31'(e1);
   assign ki_e = 31'(ki) * 31'(e1);

   always_ff @(posedge master_clk) begin
      if (reset) begin
         v2    <= 1'b0;
         p2    <= '0;
         iinc2 <= '0;
`ifdef PID_DERIVATIVE_EN
         d2    <= '0;
`endif
      end else begin
         v2 <= v1;
         if (v1) begin
            p2    <= kp_e >>> SHIFT_P;
            iinc2 <= INT_WIDTH'(ki_e);
`ifdef PID_DERIVATIVE_EN
            d2    <= kd_de >>> SHIFT_D;
`endif
         end
      end
   end

   assign integ_wide = (INT_WIDTH+1)'(integ) + (INT_WIDTH+1)'(iinc2);

   // Anti-windup compares against the rail currently held on the output register.
   always_comb begin
      integ_new = integ_wide[INT_WIDTH-1:0];
      if (integ_wide[INT_WIDTH] != integ_wide[INT_WIDTH-1])
         integ_new = integ_wide[INT_WIDTH] ? INT_MIN : INT_MAX;
      freeze = hold_int ||
               (sat && (pid_out[13] ? iinc2[INT_WIDTH-1]
                                    : (!iinc2[INT_WIDTH-1] && (iinc2 != '0))));
      integ_next = (!enable) ? '0 : (freeze ? integ : integ_new);
`ifdef PID_DERIVATIVE_EN
      sum_c = SUM_W'(p2) + SUM_W'(integ_next >>> SHIFT_I) + SUM_W'(d2);
`else
      sum_c = SUM_W'(p2) + SUM_W'(integ_next >>> SHIFT_I);
`endif
   end

   always_ff @(posedge master_clk) begin
      if (reset) begin
         v3    <= 1'b0;
         sum3  <= '0;
         integ <= '0;
      end else begin
         v3 <= v2;
         if (v2) sum3 <= sum_c;
         if (!enable)  integ <= '0;
         else if (v2)  integ <= integ_next;
      end
   end

   always_ff @(posedge master_clk) begin
      if (reset) begin
         out_valid <= 1'b0;
         pid_out   <= '0;
         sat       <= 1'b0;
      end else begin
         out_valid <= v3;
         if (v3) begin
            if (!enable) begin
               pid_out <= '0;
               sat     <= 1'b0;
            end else if (sum3 > OUT_MAX) begin
               pid_out <= 14'sd8191;
               sat     <= 1'b1;
            end else if (sum3 < OUT_MIN) begin
               pid_out <= -14'sd8192;
               sat     <= 1'b1;
            end else begin
               pid_out <= sum3[13:0];
               sat     <= 1'b0;
            end
         end
      end
   end

endmodule
